// File: rtl/pktgen_pkg.sv
// Shared definitions for the XGMII packet generator: FSM encoding, XGMII control
// characters, frame limits, latched frame configuration and the IPv4 checksum helper.
package pktgen_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StTerm  = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;

    localparam logic [7:0] XgIdle  = 8'h07;
    localparam logic [7:0] XgStart = 8'hfb;
    localparam logic [7:0] XgTerm  = 8'hfd;
    localparam logic [7:0] XgPre   = 8'h55;
    localparam logic [7:0] XgSfd   = 8'hd5;

    localparam logic [39:0] MAGIC_CODE = 40'h50_47_45_4e_31;
    localparam logic [15:0] LenMin     = 16'd64;
    localparam logic [15:0] LenMax     = 16'd1512;

    typedef struct packed {
        logic [15:0] len;
        logic [31:0] ifg;
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] udp_port;
    } frame_cfg_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len);
        logic [15:0] l;
        l = {len[15:3], 3'b000};
        if (l < LenMin) l = LenMin;
        else if (l > LenMax) l = LenMax;
        return l;
    endfunction

    // Ones-complement sum of ten header halfwords, carry folded twice.
    function automatic logic [15:0] ip_checksum(input logic [159:0] hdr);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < 10; i++) s = s + {16'h0000, hdr[16*i +: 16]};
        s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        return ~s[15:0];
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational IEEE 802.3 CRC-32 update over one 64-bit XGMII word, lane 0 first,
// bit 0 of each lane first (reflected form).
module crc32_d64 (
    input  logic [31:0] crc_i,
    input  logic [63:0] data_i,
    output logic [31:0] crc_o
);
    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 64; i++) begin
            if (c[0] ^ data_i[i]) c = (c >> 1) ^ 32'hedb88320;
            else c = c >> 1;
        end
        crc_o = c;
    end
endmodule

// File: rtl/xgmii_pktgen.sv
// Multi-channel XGMII UDP/IPv4 test-frame generator with a single shared CRC engine.
// Optional per-interval frame/byte statistics are built when PKTGEN_STATS_EN is defined.
module xgmii_pktgen
    import pktgen_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned TS_WIDTH  = 32,
    parameter int unsigned SEC_TICKS = 156250000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  tx_enable,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [15:0]           frame_len,
    input  logic [31:0]           ifg,
    input  logic [47:0]           src_mac,
    input  logic [47:0]           dst_mac,
    input  logic [31:0]           src_ip,
    input  logic [31:0]           dst_ip,
    input  logic [15:0]           udp_port,
    output logic [NUM_CH*64-1:0]  xgmii_txd,
    output logic [NUM_CH*8-1:0]   xgmii_txc,
    output logic                  tx_busy,
    output logic [31:0]           seq_num,
    output logic [31:0]           tx_pps,
    output logic [31:0]           tx_bytes
);
    logic [2:0]          state_q, state_d;
    frame_cfg_t          cfg_q, cfg_d;
    logic [NUM_CH-1:0]   mask_q;
    logic [TS_WIDTH-1:0] ts_q, ts_lat_q;
    logic [7:0]          word_q;
    logic [31:0]         gap_q, crc_q, crc_next, seq_q;
    logic [15:0]         ip_len, udp_len, ip_csum;
    logic [511:0]        hb;
    logic [63:0]         data_word, word;
    logic [7:0]          ctrl;
    logic                load;

    assign cfg_d = '{len: clamp_len(frame_len), ifg: (ifg == 32'd0) ? 32'd1 : ifg,
                     dst_mac: dst_mac, src_mac: src_mac, src_ip: src_ip, dst_ip: dst_ip,
                     udp_port: udp_port};
    assign load  = (state_d == StStart);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (tx_enable) state_d = StStart;
            StStart: state_d = StData;
            StData:  if (word_q == cfg_q.len[10:3] - 8'd1) state_d = StTerm;
            StTerm:  state_d = StGap;
            StGap:   if (gap_q == cfg_q.ifg - 32'd1) state_d = tx_enable ? StStart : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            cfg_q    <= '0;
            mask_q   <= '0;
            ts_q     <= '0;
            ts_lat_q <= '0;
            word_q   <= '0;
            gap_q    <= '0;
            crc_q    <= '1;
            seq_q    <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + TS_WIDTH'(1);
            if (load) begin
                cfg_q    <= cfg_d;
                mask_q   <= ch_mask;
                ts_lat_q <= ts_q;
            end
            if (state_q == StStart) begin
                word_q <= '0;
                crc_q  <= '1;
            end
            if (state_q == StData) begin
                word_q <= word_q + 8'd1;
                crc_q  <= crc_next;
            end
            if (state_q == StTerm) begin
                seq_q <= seq_q + 32'd1;
                gap_q <= '0;
            end
            if (state_q == StGap) gap_q <= gap_q + 32'd1;
        end
    end

    assign ip_len  = cfg_q.len - 16'd14;
    assign udp_len = cfg_q.len - 16'd34;
    assign ip_csum = ip_checksum({16'h4500, ip_len, seq_q[15:0], 16'h0000, 8'd64, 8'd17,
                                  16'h0000, cfg_q.src_ip, cfg_q.dst_ip});

    // First 64 frame bytes, byte 0 in the top octet; everything beyond is zero padding.
    assign hb = {cfg_q.dst_mac, cfg_q.src_mac, 16'h0800, 8'h45, 8'h00, ip_len, seq_q[15:0],
                 16'h0000, 8'd64, 8'd17, ip_csum, cfg_q.src_ip, cfg_q.dst_ip, cfg_q.udp_port,
                 cfg_q.udp_port, udp_len, 16'h0000, MAGIC_CODE, seq_q, ts_lat_q,
                 {(104 - TS_WIDTH){1'b0}}};

    always_comb begin
        data_word = '0;
        if (word_q < 8'd8) begin
            for (int i = 0; i < 8; i++) begin
                data_word[8*i +: 8] = hb[511 - 64*int'(word_q[2:0]) - 8*i -: 8];
            end
        end
    end

    crc32_d64 u_crc (
        .crc_i  (crc_q),
        .data_i (data_word),
        .crc_o  (crc_next)
    );

    always_comb begin
        word = {8{XgIdle}};
        ctrl = 8'hff;
        case (state_q)
            StStart: begin
                word = {XgSfd, {6{XgPre}}, XgStart};
                ctrl = 8'h01;
            end
            StData: begin
                word = data_word;
                ctrl = 8'h00;
            end
            StTerm: begin
                word = {{3{XgIdle}}, XgTerm, ~crc_q};
                ctrl = 8'hf0;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            xgmii_txd[64*c +: 64] = mask_q[c] ? word : {8{XgIdle}};
            xgmii_txc[8*c +: 8]   = mask_q[c] ? ctrl : 8'hff;
        end
    end

    assign tx_busy = (state_q != StIdle);
    assign seq_num = seq_q;

`ifdef PKTGEN_STATS_EN
    localparam int unsigned TickW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;

    logic [TickW-1:0] tick_q;
    logic [31:0]      frm_q, byt_q, pps_q, bytes_q, frame_bytes;
    logic             frame_end;

    assign frame_end   = (state_q == StTerm);
    assign frame_bytes = {16'h0000, cfg_q.len} + 32'd4;

    // A frame ending on the latch cycle belongs to the interval that starts there.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_q  <= '0;
            frm_q   <= '0;
            byt_q   <= '0;
            pps_q   <= '0;
            bytes_q <= '0;
        end else if (tick_q == TickW'(SEC_TICKS - 1)) begin
            tick_q  <= '0;
            pps_q   <= frm_q;
            bytes_q <= byt_q;
            frm_q   <= frame_end ? 32'd1 : 32'd0;
            byt_q   <= frame_end ? frame_bytes : 32'd0;
        end else begin
            tick_q <= tick_q + TickW'(1);
            if (frame_end) begin
                frm_q <= frm_q + 32'd1;
                byt_q <= byt_q + frame_bytes;
            end
        end
    end

    assign tx_pps   = pps_q;
    assign tx_bytes = bytes_q;
`else
    assign tx_pps   = '0;
    assign tx_bytes = '0;
`endif

endmodule

// File: tb/tb_xgmii_pktgen.sv
// Self-checking bench for xgmii_pktgen: builds each expected frame byte-by-byte from the
// field rules, with a software CRC-32 and IPv4 checksum, and compares every XGMII word.
module tb_xgmii_pktgen;
    import pktgen_pkg::*;

    localparam logic [63:0] IdleW = 64'h0707070707070707;

    logic         clk, rst_n, tx_enable;
    logic [1:0]   ch_mask;
    logic [15:0]  frame_len, udp_port;
    logic [31:0]  ifg, src_ip, dst_ip;
    logic [47:0]  src_mac, dst_mac;
    logic [127:0] txd;
    logic [15:0]  txc;
    logic         tx_busy;
    logic [31:0]  seq_num, tx_pps, tx_bytes;

    int checks = 0;
    int errors = 0;

    xgmii_pktgen #(
        .NUM_CH    (2),
        .TS_WIDTH  (32),
        .SEC_TICKS (1000)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .tx_enable (tx_enable),
        .ch_mask   (ch_mask),
        .frame_len (frame_len),
        .ifg       (ifg),
        .src_mac   (src_mac),
        .dst_mac   (dst_mac),
        .src_ip    (src_ip),
        .dst_ip    (dst_ip),
        .udp_port  (udp_port),
        .xgmii_txd (txd),
        .xgmii_txc (txc),
        .tx_busy   (tx_busy),
        .seq_num   (seq_num),
        .tx_pps    (tx_pps),
        .tx_bytes  (tx_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: the value the free-running timestamp has reached.
    logic [31:0] cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else cyc <= cyc + 32'd1;
    end

    logic [7:0]  fb [0:1511];
    logic [47:0] m_dst, m_src;
    logic [31:0] m_sip, m_dip, m_seq, m_ts, m_fcs, exp_seq;
    logic [15:0] m_port;
    logic [1:0]  m_mask;
    int          m_len, m_gap, last_start;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int ofs, input logic [63:0] v, input int n);
        for (int j = 0; j < n; j++) fb[ofs + j] = v[8*(n - 1 - j) +: 8];
    endtask

    task automatic build_frame();
        int s;
        logic [31:0] c;
        for (int i = 0; i < 1512; i++) fb[i] = 8'h00;
        put(0, 64'(m_dst), 6);
        put(6, 64'(m_src), 6);
        put(12, 64'h0800, 2);
        fb[14] = 8'h45;
        put(16, 64'(m_len - 14), 2);
        put(18, 64'(m_seq[15:0]), 2);
        fb[22] = 8'd64;
        fb[23] = 8'd17;
        put(26, 64'(m_sip), 4);
        put(30, 64'(m_dip), 4);
        put(34, 64'(m_port), 2);
        put(36, 64'(m_port), 2);
        put(38, 64'(m_len - 34), 2);
        put(42, 64'(MAGIC_CODE), 5);
        put(47, 64'(m_seq), 4);
        put(51, 64'(m_ts), 4);
        s = 0;
        for (int j = 0; j < 10; j++) s += {fb[14 + 2*j], fb[15 + 2*j]};
        s = (s & 'hffff) + (s >>> 16);
        s = (s & 'hffff) + (s >>> 16);
        put(24, 64'(~s[15:0]), 2);
        c = '1;
        for (int i = 0; i < m_len; i++) begin
            c ^= {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        m_fcs = ~c;
    endtask

    task automatic rand_fields();
        src_mac  = {16'($urandom), $urandom};
        dst_mac  = {16'($urandom), $urandom};
        src_ip   = $urandom;
        dst_ip   = $urandom;
        udp_port = 16'($urandom);
    endtask

    // Waits for a frame, checks every word through its last gap word; the n* arguments are
    // applied mid-frame and so take effect on the following frame.
    task automatic check_frame(input string tag, input logic [1:0] nmask,
                               input logic [15:0] nlen, input logic [31:0] nifg, input bit drop);
        int n, nw;
        logic [63:0] w;
        logic [7:0]  c;
        n = 0;
        while (tx_busy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 160'(tx_busy), 160'(1));
        if (tx_busy !== 1'b1) return;
        last_start = int'(cyc);
        m_mask = ch_mask;
        m_len  = int'(frame_len) / 8 * 8;
        if (m_len < 64) m_len = 64;
        if (m_len > 1512) m_len = 1512;
        m_gap  = (ifg == 0) ? 1 : int'(ifg);
        m_dst  = dst_mac;
        m_src  = src_mac;
        m_sip  = src_ip;
        m_dip  = dst_ip;
        m_port = udp_port;
        m_seq  = exp_seq;
        m_ts   = cyc - 32'd1;
        build_frame();
        chk({tag, "_seq"}, 160'(seq_num), 160'(exp_seq));
        nw = m_len / 8;
        for (int k = 0; k < nw + 2 + m_gap; k++) begin
            if (k == 2) begin
                ch_mask   = nmask;
                frame_len = nlen;
                ifg       = nifg;
                rand_fields();
                if (drop) tx_enable = 1'b0;
            end
            if (k == 0) begin
                w = 64'hd5555555555555fb;
                c = 8'h01;
            end else if (k <= nw) begin
                for (int i = 0; i < 8; i++) w[8*i +: 8] = fb[8*(k - 1) + i];
                c = 8'h00;
            end else if (k == nw + 1) begin
                w = {24'h070707, 8'hfd, m_fcs};
                c = 8'hf0;
            end else begin
                w = IdleW;
                c = 8'hff;
            end
            chk($sformatf("%s_w%0d", tag, k), 160'({tx_busy, txc, txd}),
                160'({1'b1, m_mask[1] ? c : 8'hff, m_mask[0] ? c : 8'hff,
                      m_mask[1] ? w : IdleW, m_mask[0] ? w : IdleW}));
            @(negedge clk);
        end
        exp_seq = exp_seq + 32'd1;
        chk({tag, "_seq_next"}, 160'(seq_num), 160'(exp_seq));
    endtask

    initial begin
        int s0;
        bit ok;
        rst_n = 1'b0;
        tx_enable = 1'b0;
        ch_mask = 2'b11;
        frame_len = 16'd64;
        ifg = 32'd1;
        exp_seq = '0;
        rand_fields();
        repeat (2) @(negedge clk);
        chk("reset_lanes", 160'({tx_busy, txc, txd}), 160'({1'b0, 16'hffff, IdleW, IdleW}));
        chk("reset_seq", 160'(seq_num), 160'(0));
        chk("reset_stats", 160'({tx_pps, tx_bytes}), 160'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_enable", 160'({tx_busy, txc, txd}), 160'({1'b0, 16'hffff, IdleW, IdleW}));

        // Minimum frames back to back: 11-cycle period, seq 0,1,2.
        tx_enable = 1'b1;
        check_frame("min0", 2'b11, 16'd64, 32'd1, 1'b0);
        s0 = last_start;
        check_frame("min1", 2'b11, 16'd64, 32'd1, 1'b0);
        chk("period01", 160'(last_start - s0), 160'(11));
        s0 = last_start;
        check_frame("min2", 2'b11, 16'd1515, 32'd0, 1'b0);
        chk("period12", 160'(last_start - s0), 160'(11));

        // Length clamps, zero gap, mask change mid-frame.
        check_frame("len1515", 2'b11, 16'd20, 32'd3, 1'b0);
        check_frame("len20", 2'b01, 16'(($urandom_range(64, 300))), 32'd2, 1'b0);
        check_frame("mask_chg", 2'b01, 16'(($urandom_range(0, 300))), 32'(($urandom_range(0, 5))),
                    1'b0);
        check_frame("mask01", 2'(($urandom)), 16'(($urandom_range(0, 300))),
                    32'(($urandom_range(0, 5))), 1'b0);
        for (int f = 0; f < 4; f++) begin
            check_frame($sformatf("rnd%0d", f), 2'(($urandom)), 16'(($urandom_range(0, 400))),
                        32'(($urandom_range(0, 6))), 1'b0);
        end

        // Enable dropped mid-frame: frame and gap complete, then idle.
        ch_mask = 2'b11;
        check_frame("drop", 2'b11, 16'd72, 32'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("after_drop%0d", i), 160'({tx_busy, txc, txd}),
                160'({1'b0, 16'hffff, IdleW, IdleW}));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a frame.
        tx_enable = 1'b1;
        for (int i = 0; i < 400 && tx_busy !== 1'b1; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_lanes", 160'({tx_busy, txc, txd}), 160'({1'b0, 16'hffff, IdleW, IdleW}));
        chk("midreset_seq", 160'(seq_num), 160'(0));
        exp_seq = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("post_reset", 2'b11, 16'd64, 32'd1, 1'b0);

        // Statistics over full intervals of 64-byte frames at ifg 1.
        rst_n = 1'b0;
        @(negedge clk);
        ch_mask = 2'b11;
        frame_len = 16'd64;
        ifg = 32'd1;
        rst_n = 1'b1;
        repeat (2100) @(negedge clk);
`ifdef PKTGEN_STATS_EN
        ok = (tx_pps == 32'd90 && tx_bytes == 32'd6120) ||
             (tx_pps == 32'd91 && tx_bytes == 32'd6188);
        chk("stats_interval", 160'({tx_pps, tx_bytes, 31'd0, ok}), 160'({tx_pps, tx_bytes, 32'd1}));
`else
        ok = 1'b1;
        chk("stats_tied", 160'({tx_pps, tx_bytes}), 160'(0));
`endif
        tx_enable = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xgmii_pktgen.md
XGMII_PKTGEN -- requirements
Module: xgmii_pktgen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of XGMII TX channels, legal 1..4.
REQ-002 SHALL have parameter TS_WIDTH, default 32: width of the embedded timestamp in bits; multiple of 8, legal 24..40.
REQ-003 SHALL have parameter SEC_TICKS, default 156250000: sys_clk cycles per statistics interval.
REQ-004 SHALL have port sys_clk  in  1  sole clock, 156.25 MHz.
REQ-005 SHALL have port sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_enable  in  1  run request.
REQ-007 SHALL have port ch_mask  in  NUM_CH  per-channel transmit enable.
REQ-008 SHALL have port frame_len  in  16  frame bytes excluding preamble and FCS.
REQ-009 SHALL have port ifg  in  32  idle words inserted after the terminate word.
REQ-010 SHALL have ports src_mac/dst_mac  in  48 each, src_ip/dst_ip  in  32 each, and udp_port  in  16 (UDP source and destination port).
REQ-011 SHALL have port xgmii_txd  out  NUM_CH*64  channel c occupies bits [64c+63:64c].
REQ-012 SHALL have port xgmii_txc  out  NUM_CH*8  channel c occupies bits [8c+7:8c].
REQ-013 SHALL have port tx_busy  out  1  high from the start word through the last gap word.
REQ-014 SHALL have port seq_num  out  32  sequence number of the next frame.
REQ-015 SHALL have ports tx_pps and tx_bytes  out  32 each  carrying per-interval statistics.

Function
REQ-016 SHALL implement the FSM IDLE -> START -> DATA -> TERM -> GAP, with GAP returning to START when tx_enable=1 and to IDLE otherwise.
REQ-017 SHALL leave IDLE for START when it samples tx_enable=1; the start word SHALL be driven one cycle later.
REQ-018 SHALL latch frame_len, ifg, ch_mask, MACs, IPs, udp_port and the timestamp on entry to START; input changes mid-frame SHALL NOT alter the frame in flight.
REQ-019 SHALL ignore frame_len[2:0] and clamp the result to 64..1512 bytes; SHALL clamp ifg=0 to 1.
REQ-020 SHALL drive the start word as txc=0x01 with lanes fb,55,55,55,55,55,55,d5.
REQ-021 SHALL follow the start word with frame_len/8 data words at txc=0x00.
REQ-022 SHALL drive the terminate word as txc=0xf0, with FCS in lanes 0-3 and fd,07,07,07 in lanes 4-7.
REQ-023 SHALL drive ifg words of txc=0xff, data 0x0707070707070707; frame period is frame_len/8+2+ifg cycles.
REQ-024 SHALL compute FCS as IEEE 802.3 CRC-32 over dst_mac through the last data byte.
REQ-025 SHALL build the frame as Ethernet type 0x0800, then an IPv4 header (0x45, TOS 0, total length frame_len-14, id seq_num[15:0], TTL 64, protocol 17), then a UDP header (length frame_len-34, checksum 0).
REQ-026 SHALL compute the IPv4 header checksum as a ones-complement sum with end-around carry folded twice, then inverted.
REQ-027 SHALL place the payload as follows: bytes 42-46 MAGIC_CODE, bytes 47-50 seq_num big-endian, the next TS_WIDTH/8 bytes the timestamp big-endian, remaining bytes 0x00.
REQ-028 SHALL hold a free-running TS_WIDTH-bit timestamp counter that increments every cycle and wraps to 0.
REQ-029 SHALL increment seq_num by 1 in the TERM cycle, wrapping from 0xffffffff to 0.
REQ-030 SHALL drive a channel whose latched mask bit is 0 with continuous idle; a frame SHALL never be truncated on any channel.
REQ-031 SHALL, when tx_enable is deasserted mid-frame, complete the current frame and its gap before entering IDLE.

Reset
REQ-032 SHALL, while sys_rst_n=0, immediately place the FSM in IDLE and drive idle on all channels, regardless of the frame in progress.
REQ-033 SHALL reset tx_busy=0, seq_num=0, the timestamp counter to 0, tx_pps=0 and tx_bytes=0.

Configuration
REQ-034 SHALL, with PKTGEN_STATS_EN defined, count frames and bytes (frame_len+4 per frame) and latch them into tx_pps/tx_bytes every SEC_TICKS cycles; the counters SHALL clear on the latch cycle, with a frame ending on that same cycle counted in the new interval.
REQ-035 SHALL, with PKTGEN_STATS_EN undefined, tie tx_pps and tx_bytes to 0 and omit the interval counter.

Structure
REQ-036 SHALL place the FSM state encoding, the XGMII control characters (07, fb, fd, 55, d5), MAGIC_CODE and the frame length limits in package pktgen_pkg.
REQ-037 SHALL instantiate exactly one crc32_d64 sub-module, shared by all channels.

Verification
REQ-038 SHALL verify that frame_len=64, ifg=1, tx_enable held high gives an 11-cycle period, the FCS checks by a software CRC, and seq_num steps 0,1,2.
REQ-039 SHALL verify that frame_len=1515 transmits as 1512 bytes and frame_len=20 transmits as 64 bytes.
REQ-040 SHALL verify that ch_mask changed from 2'b11 to 2'b01 mid-frame leaves both channels completing the frame, with channel 1 idle from the next frame.
REQ-041 SHALL verify that tx_enable dropped in DATA completes the frame and its ifg words, then tx_busy=0.
REQ-042 SHALL verify that sys_rst_n asserted mid-frame makes all lanes 0x07 with txc=0xff from the reset edge, and seq_num=0.
REQ-043 SHALL verify, with PKTGEN_STATS_EN, SEC_TICKS=1000 and 64-byte frames at ifg=1, tx_pps=90 and tx_bytes=6120, or 91 and 6188 depending on phase.
